// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one op in flight, fixed 34-cycle start-to-done latency.
// A single 64-bit accumulator holds the {hi,lo} product or the {remainder,quotient} pair.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wr_en
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  // CALC holds one extra cycle at cnt==XLEN so that the overall latency lands on 34.
  localparam logic [5:0] LAST = 6'(XLEN);

  state_t            state, state_nx;
  logic [5:0]        cnt;
  logic [2:0]        f3;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic              neg_q, neg_r;

  logic              accept;
  logic              is_div_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [XLEN:0]     mul_sum, div_sh, div_df;
  logic [2*XLEN-1:0] mul_nx, div_nx, prod;
  logic [XLEN-1:0]   quo, rem, fix_val;

  assign accept = (state == IDLE) & start & ~flush;

  always_comb begin
    is_div_in = funct3[2];
    a_sgn_in  = is_div_in ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
    b_sgn_in  = is_div_in ? ~funct3[0] : (funct3 == 3'b001);
    a_neg_in  = a_sgn_in & op_a[XLEN-1];
    b_neg_in  = b_sgn_in & op_b[XLEN-1];
    a_abs     = a_neg_in ? -op_a : op_a;
    b_abs     = b_neg_in ? -op_b : op_b;
  end

  // One step per cycle: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
    mul_nx  = {mul_sum, acc[XLEN-1:1]};
    div_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_df  = div_sh - {1'b0, opnd};
    div_nx  = div_df[XLEN] ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                           : {div_df[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (f3)
      3'b000:         fix_val = prod[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         fix_val = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101: fix_val = (opnd == '0) ? {XLEN{1'b1}} : quo;
      default:        fix_val = (opnd == '0) ? a_q : rem;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (cnt == LAST) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      f3    <= '0;
      rd_q  <= '0;
      a_q   <= '0;
      opnd  <= '0;
      acc   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      f3    <= funct3;
      rd_q  <= rd_in;
      a_q   <= op_a;
      opnd  <= is_div_in ? b_abs : a_abs;
      acc   <= {{XLEN{1'b0}}, (is_div_in ? a_abs : b_abs)};
      neg_q <= a_neg_in ^ b_neg_in;
      neg_r <= a_neg_in;
    end else if (state == CALC && cnt != LAST) begin
      acc <= f3[2] ? div_nx : mul_nx;
      cnt <= cnt + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= '0;
      rd_out <= '0;
    end else if (state == FIX && !flush) begin
      result <= fix_val;
      rd_out <= rd_q;
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign wr_en = done & (rd_out != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, arithmetic corner cases, handshake, flush and reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  funct3;
  logic [4:0]  rd_in;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        busy, done, wr_en;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct3(funct3), .rd_in(rd_in),
    .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out), .wr_en(wr_en)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;

  // Issue one op; report cycles from accept edge to done, the done-cycle outputs,
  // whether busy stayed high throughout, and whether the following cycle is quiet.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat, output logic [31:0] res,
                       output logic [4:0] rdo, output logic wr, output logic busy_ok,
                       output logic after_ok);
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; busy_ok = busy; res = '0; rdo = '0; wr = 1'b0; after_ok = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
      if (!busy) busy_ok = 1'b0;
    end
    if (lat > 0) begin
      res = result; rdo = rd_out; wr = wr_en; busy_ok = busy_ok & busy;
      @(posedge clk); #1;
      after_ok = !done && !wr_en && !busy;
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int          ia, ib;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    ua = {32'd0, a};       ub = {32'd0, b};
    ia = a; ib = b;
    case (f)
      3'b000: begin p = ua * ub; return p[31:0];  end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: if (b == 0) return 32'hFFFF_FFFF;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
              else return ia / ib;
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: if (b == 0) return a;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
              else return ia % ib;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic test_reset;
    n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0)  begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL reset_result got=%h exp=0", result); end
    n_cmp++; if (rd_out !== 5'd0)  begin n_err++; $display("FAIL reset_rd_out got=%0d exp=0", rd_out); end
  endtask

  task automatic test_mul;
    int lat; logic [31:0] res; logic [4:0] rdo; logic wr, bok, aok;
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, lat, res, rdo, wr, bok, aok);
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL mul_latency got=%0d exp=34", lat); end
    n_cmp++; if (res !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_result got=%h exp=ffffffeb", res); end
    n_cmp++; if (rdo !== 5'd5) begin n_err++; $display("FAIL mul_rd_out got=%0d exp=5", rdo); end
    n_cmp++; if (wr !== 1'b1) begin n_err++; $display("FAIL mul_wr_en got=%b exp=1", wr); end
    n_cmp++; if (bok !== 1'b1) begin n_err++; $display("FAIL mul_busy_hold got=%b exp=1", bok); end
    n_cmp++; if (aok !== 1'b1) begin n_err++; $display("FAIL mul_done_pulse got=%b exp=1", aok); end
  endtask

  task automatic test_vectors(input string name, input logic [2:0] f[4], input logic [31:0] a[4],
                              input logic [31:0] b[4], input logic [31:0] e[4], input int n);
    int lat; logic [31:0] res; logic [4:0] rdo; logic wr, bok, aok;
    for (int i = 0; i < n; i++) begin
      do_op(f[i], a[i], b[i], 5'd3, lat, res, rdo, wr, bok, aok);
      n_cmp++;
      if (res !== e[i]) begin
        n_err++; $display("FAIL %s[%0d] f=%0d a=%h b=%h got=%h exp=%h", name, i, f[i], a[i], b[i], res, e[i]);
      end
      n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL %s_latency[%0d] got=%0d exp=34", name, i, lat); end
    end
  endtask

  task automatic test_mulh;
    logic [2:0] f[4]; logic [31:0] a[4], b[4], e[4];
    f = '{3'b001, 3'b011, 3'b010, 3'b000};
    a = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    b = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    e = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0};
    test_vectors("mulh", f, a, b, e, 3);
  endtask

  task automatic test_div;
    logic [2:0] f[4]; logic [31:0] a[4], b[4], e[4];
    f = '{3'b100, 3'b110, 3'b101, 3'b111};
    a = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    b = '{32'd2, 32'd2, 32'd7, 32'd7};
    e = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    test_vectors("div", f, a, b, e, 4);
  endtask

  task automatic test_special;
    logic [2:0] f[4]; logic [31:0] a[4], b[4], e[4];
    f = '{3'b100, 3'b110, 3'b100, 3'b110};
    a = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    b = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    e = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    test_vectors("special", f, a, b, e, 4);
  endtask

  task automatic test_reset_mid;
    int d0;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; rd_in = 5'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #3; reset_n = 1'b0; #1;
    test_reset();
    d0 = done_cnt;
    @(negedge clk); reset_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    n_cmp++; if (done_cnt !== d0) begin n_err++; $display("FAIL reset_mid_no_done got=%0d exp=%0d", done_cnt, d0); end
  endtask

  task automatic test_flush;
    int d0; logic [31:0] r0; logic [4:0] rd0;
    r0 = result; rd0 = rd_out; d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd9;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got=%b exp=0", busy); end
    repeat (45) @(posedge clk);
    #1;
    n_cmp++; if (done_cnt !== d0) begin n_err++; $display("FAIL flush_no_done got=%0d exp=%0d", done_cnt, d0); end
    n_cmp++; if (result !== r0 || rd_out !== rd0) begin
      n_err++; $display("FAIL flush_hold got=%h/%0d exp=%h/%0d", result, rd_out, r0, rd0);
    end
    // flush and start together: the op is not accepted
    @(negedge clk); start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_prio_busy got=%b exp=0", busy); end
    repeat (40) @(posedge clk);
    #1;
    n_cmp++; if (done_cnt !== d0) begin n_err++; $display("FAIL flush_prio_no_done got=%0d exp=%0d", done_cnt, d0); end
  endtask

  task automatic test_busy_start;
    int d0, lat;
    d0 = done_cnt; lat = -1;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7; rd_in = 5'd4;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd11; op_b = 32'd13; rd_in = 5'd8;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 6; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL busy_start_latency got=%0d exp=34", lat); end
    n_cmp++; if (result !== 32'd42 || rd_out !== 5'd4) begin
      n_err++; $display("FAIL busy_start_result got=%h/%0d exp=0000002a/4", result, rd_out);
    end
    repeat (45) @(posedge clk);
    #1;
    n_cmp++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL busy_start_one_done got=%0d exp=%0d", done_cnt - d0, 1); end
  endtask

  task automatic test_rd_zero;
    int lat; logic [31:0] res; logic [4:0] rdo; logic wr, bok, aok;
    do_op(3'b011, 32'd3, 32'd4, 5'd0, lat, res, rdo, wr, bok, aok);
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL rd0_done got_latency=%0d exp=34", lat); end
    n_cmp++; if (wr !== 1'b0) begin n_err++; $display("FAIL rd0_wr_en got=%b exp=0", wr); end
    n_cmp++; if (res !== 32'd0 || rdo !== 5'd0) begin n_err++; $display("FAIL rd0_result got=%h/%0d exp=0/0", res, rdo); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] res; logic [4:0] rdo; logic wr, bok, aok;
    do_op(3'b000, 32'd123, 32'd456, 5'd1, lat, res, rdo, wr, bok, aok);
    n_cmp++; if (res !== 32'd56088 || !aok) begin n_err++; $display("FAIL b2b_first got=%h quiet=%b exp=0000db18 quiet=1", res, aok); end
    do_op(3'b111, 32'd1000, 32'd7, 5'd31, lat, res, rdo, wr, bok, aok);
    n_cmp++; if (res !== 32'd6 || rdo !== 5'd31 || lat !== 34) begin
      n_err++; $display("FAIL b2b_second got=%h/%0d lat=%0d exp=00000006/31 lat=34", res, rdo, lat);
    end
  endtask

  task automatic test_random;
    int lat; logic [31:0] res, a, b, e; logic [4:0] rdo; logic wr, bok, aok; logic [2:0] f;
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      e = ref_op(f, a, b);
      do_op(f, a, b, 5'(i % 32), lat, res, rdo, wr, bok, aok);
      n_cmp++;
      if (res !== e || lat !== 34) begin
        n_err++; $display("FAIL random[%0d] f=%0d a=%h b=%h got=%h lat=%0d exp=%h lat=34", i, f, a, b, res, lat, e);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; funct3 = '0; rd_in = '0; op_a = '0; op_b = '0; flush = 1'b0;
    #23;
    test_reset();
    @(negedge clk); reset_n = 1'b1;
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_reset_mid();
    test_mul();
    test_flush();
    test_busy_start();
    test_rd_zero();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
